// File: rtl/cover_toggle_collector.sv
// Toggle-cover collector: records first-time hits of a WIDTH-bit hit vector in a
// sticky bitmap and streams each newly covered absolute index once through a
// small report FIFO with a valid/ready read port.
module cover_toggle_collector #(
  parameter int unsigned WIDTH       = 9,
  parameter int unsigned COVER_INDEX = 0,
  parameter int unsigned COVER_TOTAL = 9715,
  parameter int unsigned IDX_W       = 64,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [CNT_W-1:0] hit_count,
  output logic             all_covered,
  output logic             busy
);

  localparam int unsigned BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  logic [WIDTH-1:0]  seen_q, seen_d;
  logic [WIDTH-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0]  hit_count_q, hit_count_d;
  logic [BIT_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [BIT_W-1:0]  fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic [WIDTH-1:0]  new_hits;
  logic [WIDTH-1:0]  sel_mask;
  logic [BIT_W-1:0]  sel_idx;
  logic [CNT_W-1:0]  new_cnt;
  logic              pop;
  logic              push;
  logic              can_push;

  // Output views derived directly from registered state
  assign out_valid   = (fcnt_q != '0);
  assign out_index   = out_valid ? (IDX_W'(COVER_INDEX) + IDX_W'(fifo_q[rd_ptr_q])) : '0;
  assign hit_count   = hit_count_q;
  assign all_covered = &seen_q;
  assign busy        = (|pending_q) | out_valid;

  // Sample new hits, select lowest pending bit for the FIFO, handle pop and clear
  always_comb begin
    new_hits    = '0;
    sel_mask    = '0;
    sel_idx     = '0;
    new_cnt     = '0;
    seen_d      = seen_q;
    pending_d   = pending_q;
    hit_count_d = hit_count_q;
    fifo_d      = fifo_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fcnt_d      = fcnt_q;

    if (enable) new_hits = valid & ~seen_q;

    for (int i = 0; i < int'(WIDTH); i++) begin
      new_cnt = new_cnt + CNT_W'(new_hits[i]);
    end

    // Scan from the top so the lowest set bit wins
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_idx     = BIT_W'(i);
        sel_mask    = '0;
        sel_mask[i] = 1'b1;
      end
    end

    pop      = out_valid & out_ready;
    can_push = (fcnt_q != FCNT_W'(FIFO_DEPTH)) | pop;
    push     = (|pending_q) & can_push;

    seen_d      = seen_q | new_hits;
    pending_d   = (pending_q | new_hits) & ~(push ? sel_mask : '0);
    hit_count_d = hit_count_q + new_cnt;

    if (push) begin
      fifo_d[wr_ptr_q] = sel_idx;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    fcnt_d = fcnt_q + FCNT_W'(push) - FCNT_W'(pop);

    // Clear wins over sampling, selection and popping
    if (clear) begin
      seen_d      = '0;
      pending_d   = '0;
      hit_count_d = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      fcnt_d      = '0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seen_q      <= '0;
      pending_q   <= '0;
      hit_count_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fcnt_q      <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      seen_q      <= seen_d;
      pending_q   <= pending_d;
      hit_count_q <= hit_count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fcnt_q      <= fcnt_d;
      fifo_q      <= fifo_d;
    end
  end

`ifndef SYNTHESIS
  // Index range sanity checks (simulation only)
  always @(posedge clock) begin
    if (!reset) begin
      assert (COVER_INDEX + WIDTH <= COVER_TOTAL)
        else $error("cover group exceeds COVER_TOTAL");
      if (out_valid) begin
        assert (out_index < IDX_W'(COVER_TOTAL))
          else $error("out_index %0d out of range", out_index);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Directed bench for cover_toggle_collector (default parameters, WIDTH=9, depth 4).
module tb_cover_toggle_collector;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        clear;
  logic [8:0]  valid;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_index;
  logic [3:0]  hit_count;
  logic        all_covered;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  cover_toggle_collector dut (
    .clock      (clk),
    .reset      (rst),
    .enable     (enable),
    .clear      (clear),
    .valid      (valid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .hit_count  (hit_count),
    .all_covered(all_covered),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled at the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clear = 1'b0; valid = '0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_index", out_index, 64'd0);
    check("rst_hit_count", 64'(hit_count), 64'd0);
    check("rst_all_covered", 64'(all_covered), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single hit, single report, no re-report
    enable = 1'b1; out_ready = 1'b1; valid = 9'h001;
    tick();
    valid = '0;
    check("t1_no_valid_yet", 64'(out_valid), 64'd0);
    check("t1_hit_count", 64'(hit_count), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    tick();
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_out_index", out_index, 64'd0);
    tick();
    check("t1_one_beat", 64'(out_valid), 64'd0);
    check("t1_idle", 64'(busy), 64'd0);
    valid = 9'h001;
    tick();
    valid = '0;
    tick();
    tick();
    check("t1_no_repeat", 64'(out_valid), 64'd0);
    check("t1_count_kept", 64'(hit_count), 64'd1);

    // 2: all bits at once, ascending stream one per cycle
    do_clear();
    valid = 9'h1FF;
    tick();
    valid = '0;
    check("t2_hit_count", 64'(hit_count), 64'd9);
    check("t2_all_covered", 64'(all_covered), 64'd1);
    tick();
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t2_valid_%0d", i), 64'(out_valid), 64'd1);
      check($sformatf("t2_index_%0d", i), out_index, 64'(i));
      tick();
    end
    check("t2_drained", 64'(out_valid), 64'd0);
    check("t2_busy", 64'(busy), 64'd0);

    // 3: backpressure fills FIFO, rest stays pending
    do_clear();
    out_ready = 1'b0; valid = 9'h1FF;
    tick();
    valid = '0;
    for (int i = 0; i < 6; i++) tick();
    check("t3_full", 64'(dut.fcnt_q), 64'd4);
    check("t3_pending", 64'(dut.pending_q), 64'h1F0);
    check("t3_head_held", out_index, 64'd0);
    check("t3_busy", 64'(busy), 64'd1);

    // 4: pop and push in the same cycle on a full FIFO
    out_ready = 1'b1;
    tick();
    check("t4_count_stays", 64'(dut.fcnt_q), 64'd4);
    check("t4_head", out_index, 64'd1);
    for (int i = 1; i < 9; i++) begin
      check($sformatf("t4_valid_%0d", i), 64'(out_valid), 64'd1);
      check($sformatf("t4_index_%0d", i), out_index, 64'(i));
      tick();
    end
    check("t4_drained", 64'(out_valid), 64'd0);
    check("t4_busy", 64'(busy), 64'd0);

    // 5: clear beats hits and pops in the same cycle
    do_clear();
    out_ready = 1'b0; valid = 9'h003;
    tick();
    valid = '0;
    tick();
    check("t5_pre_valid", 64'(out_valid), 64'd1);
    clear = 1'b1; valid = 9'h003; out_ready = 1'b1;
    tick();
    clear = 1'b0; valid = '0;
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_hit_count", 64'(hit_count), 64'd0);
    check("t5_seen", 64'(dut.seen_q), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    valid = 9'h003;
    tick();
    valid = '0;
    tick();
    check("t5_idx0", out_index, 64'd0);
    tick();
    check("t5_idx1", out_index, 64'd1);
    tick();
    check("t5_done", 64'(out_valid), 64'd0);
    check("t5_count", 64'(hit_count), 64'd2);

    // 6: async reset mid-drain, then disabled sampling
    do_clear();
    valid = 9'h1FF;
    tick();
    valid = '0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_index", out_index, 64'd0);
    check("t6_rst_count", 64'(hit_count), 64'd0);
    check("t6_rst_allcov", 64'(all_covered), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0; enable = 1'b0; valid = 9'h1FF;
    tick();
    tick();
    tick();
    valid = '0;
    check("t6_dis_valid", 64'(out_valid), 64'd0);
    check("t6_dis_count", 64'(hit_count), 64'd0);
    check("t6_dis_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
